// File: rtl/mem_stage_ctrl_multi.sv
// rtl/mem_stage_ctrl_multi.sv - MEM-stage control: LW/SW strobes and LM/SM register-list bursts
module mem_stage_ctrl_multi #(
   parameter int                OPC_W     = 4,
   parameter int                ADDR_W    = 16,
   parameter int                NUM_REGS  = 8,
   parameter int                ADDR_STEP = 2,
   parameter logic [OPC_W-1:0]  OPC_LW    = OPC_W'(4'b0100),
   parameter logic [OPC_W-1:0]  OPC_SW    = OPC_W'(4'b0101),
   parameter logic [OPC_W-1:0]  OPC_LM    = OPC_W'(4'b0110),
   parameter logic [OPC_W-1:0]  OPC_SM    = OPC_W'(4'b0111),
   localparam int               IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       ex_mem_ir,
   input  logic              ex_mem_valid,
   input  logic [ADDR_W-1:0] ex_mem_addr,
   output logic              mem_wr_en,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [IDX_W-1:0]  reg_idx,
   output logic              mem_wb_en,
   output logic              burst_active,
   output logic              stall
);

   localparam int CNT_W = $clog2(NUM_REGS + 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t              state_q, state_d;
   logic [NUM_REGS-1:0] mask_q, mask_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                op_sm_q, op_sm_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_d, rd_d, wb_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [IDX_W-1:0]    idx_d;

   logic [OPC_W-1:0]    opc;
   logic [NUM_REGS-1:0] list;
   logic [NUM_REGS-1:0] src_mask, rem_mask;
   logic [IDX_W-1:0]    pick;
   logic                is_lm_sm, is_sm, is_multi;
   logic                unused_ir_bits;

   // Lowest set bit wins: the descending scan leaves the smallest index last.
   function automatic logic [IDX_W-1:0] lowest_bit(input logic [NUM_REGS-1:0] m);
      lowest_bit = '0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (m[i]) lowest_bit = IDX_W'(i);
      end
   endfunction

   assign opc            = ex_mem_ir[15 -: OPC_W];
   assign list           = ex_mem_ir[NUM_REGS-1:0];
   assign unused_ir_bits = ^ex_mem_ir[15-OPC_W:NUM_REGS];
   assign is_lm_sm       = (opc == OPC_LM) || (opc == OPC_SM);
   assign is_sm          = (opc == OPC_SM);
   assign is_multi       = ex_mem_valid && is_lm_sm && (list != '0);

   // In IDLE the list comes straight from the instruction; in BURST from the latched mask.
   assign src_mask = (state_q == S_BURST) ? mask_q : list;
   assign pick     = lowest_bit(src_mask);
   assign rem_mask = src_mask & ~(NUM_REGS'(1) << pick);

   assign stall        = (state_q == S_BURST);
   assign burst_active = (state_q == S_BURST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mask_q    <= '0;
         base_q    <= '0;
         op_sm_q   <= 1'b0;
         cnt_q     <= '0;
         mem_wr_en <= 1'b0;
         mem_rd_en <= 1'b0;
         mem_wb_en <= 1'b0;
         mem_addr  <= '0;
         reg_idx   <= '0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         base_q    <= base_d;
         op_sm_q   <= op_sm_d;
         cnt_q     <= cnt_d;
         mem_wr_en <= wr_d;
         mem_rd_en <= rd_d;
         mem_wb_en <= wb_d;
         mem_addr  <= addr_d;
         reg_idx   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (is_multi && (rem_mask != '0)) state_d = S_BURST;
         S_BURST: if (rem_mask == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      wb_d    = 1'b0;
      addr_d  = mem_addr;
      idx_d   = reg_idx;
      mask_d  = mask_q;
      base_d  = base_q;
      op_sm_d = op_sm_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (is_multi) begin
               op_sm_d = is_sm;
               wr_d    = is_sm;
               rd_d    = !is_sm;
               wb_d    = !is_sm;
               addr_d  = ex_mem_addr;
               idx_d   = pick;
               base_d  = ex_mem_addr;
               mask_d  = rem_mask;
               cnt_d   = CNT_W'(1);
            end else if (ex_mem_valid && (opc == OPC_LW)) begin
               rd_d   = 1'b1;
               wb_d   = 1'b1;
               addr_d = ex_mem_addr;
            end else if (ex_mem_valid && (opc == OPC_SW)) begin
               wr_d   = 1'b1;
               addr_d = ex_mem_addr;
            end else if (ex_mem_valid && !is_lm_sm) begin
               wb_d = 1'b1;
            end
         end
         S_BURST: begin
            wr_d   = op_sm_q;
            rd_d   = !op_sm_q;
            wb_d   = !op_sm_q;
            addr_d = base_q + ADDR_W'(cnt_q) * ADDR_W'(ADDR_STEP);
            idx_d  = pick;
            mask_d = rem_mask;
            cnt_d  = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_ctrl_multi.sv
// tb/tb_mem_stage_ctrl_multi.sv - randomized self-checking bench against a per-instruction access-list model
module tb_mem_stage_ctrl_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ex_mem_ir;
   logic        ex_mem_valid;
   logic [15:0] ex_mem_addr;
   logic        mem_wr_en, mem_rd_en, mem_wb_en, burst_active, stall;
   logic [15:0] mem_addr;
   logic [2:0]  reg_idx;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        wr, rd, wb, stl;
      logic [15:0] addr;
      logic [2:0]  idx;
      bit          chk_addr, chk_idx;
   } rec_t;

   rec_t q[$];

   mem_stage_ctrl_multi dut (
      .clk(clk), .rst(rst), .ex_mem_ir(ex_mem_ir), .ex_mem_valid(ex_mem_valid),
      .ex_mem_addr(ex_mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr), .reg_idx(reg_idx), .mem_wb_en(mem_wb_en),
      .burst_active(burst_active), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic rec_t mk(input logic wr, rd, wb, stl, input logic [15:0] a,
                               input logic [2:0] i, input bit ca, ci);
      rec_t r;
      r.wr = wr; r.rd = rd; r.wb = wb; r.stl = stl;
      r.addr = a; r.idx = i; r.chk_addr = ca; r.chk_idx = ci;
      return r;
   endfunction

   // Expands one accepted instruction into the full list of per-cycle outputs it produces.
   task automatic expand(input logic v, input logic [15:0] ir, input logic [15:0] a);
      logic [3:0] opc;
      logic [7:0] lst;
      int n, k;
      opc = ir[15:12];
      lst = ir[7:0];
      if (!v)              q.push_back(mk(0, 0, 0, 0, 16'h0, 3'd0, 0, 0));
      else if (opc == 4'd4) q.push_back(mk(0, 1, 1, 0, a, 3'd0, 1, 0));
      else if (opc == 4'd5) q.push_back(mk(1, 0, 0, 0, a, 3'd0, 1, 0));
      else if (opc == 4'd6 || opc == 4'd7) begin
         if (lst == 8'h00) q.push_back(mk(0, 0, 0, 0, 16'h0, 3'd0, 0, 0));
         else begin
            n = $countones(lst);
            k = 0;
            for (int b = 0; b < 8; b++) begin
               if (lst[b]) begin
                  q.push_back(mk(opc == 4'd7, opc == 4'd6, opc == 4'd6, k < n - 1,
                                 16'(a + 16'(k * 2)), 3'(b), 1, 1));
                  k++;
               end
            end
         end
      end else q.push_back(mk(0, 0, 1, 0, 16'h0, 3'd0, 0, 0));
   endtask

   task automatic step(input logic r, input logic v, input logic [15:0] ir, input logic [15:0] a,
                       input string tag);
      rec_t e;
      rst = r; ex_mem_valid = v; ex_mem_ir = ir; ex_mem_addr = a;
      if (r) begin
         q.delete();
         e = mk(0, 0, 0, 0, 16'h0, 3'd0, 1, 1);
      end else begin
         if (q.size() == 0) expand(v, ir, a);
         e = q.pop_front();
      end
      @(posedge clk);
      #1;
      check_eq({tag, ".wr"}, 32'(mem_wr_en), 32'(e.wr));
      check_eq({tag, ".rd"}, 32'(mem_rd_en), 32'(e.rd));
      check_eq({tag, ".wb"}, 32'(mem_wb_en), 32'(e.wb));
      check_eq({tag, ".stall"}, 32'(stall), 32'(e.stl));
      check_eq({tag, ".burst"}, 32'(burst_active), 32'(e.stl));
      if (e.chk_addr) check_eq({tag, ".addr"}, 32'(mem_addr), 32'(e.addr));
      if (e.chk_idx)  check_eq({tag, ".idx"}, 32'(reg_idx), 32'(e.idx));
      @(negedge clk);
   endtask

   function automatic logic [15:0] ins(input logic [3:0] opc, input logic [7:0] lst);
      return {opc, 4'($urandom), lst};
   endfunction

   task automatic junk(input string tag);
      step(0, 1'($urandom), 16'($urandom), 16'($urandom), tag);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 10 && q.size() > 0; i++) junk(tag);
   endtask

   initial begin
      logic [3:0] opc;
      int sel;
      rst = 1'b1; ex_mem_valid = 1'b0; ex_mem_ir = '0; ex_mem_addr = '0;
      @(negedge clk);
      step(1, 0, 16'h0, 16'h0, "rst0");
      step(1, 0, 16'h0, 16'h0, "rst1");
      step(0, 0, 16'h0, 16'h0, "bubble");

      step(0, 1, ins(4'd4, 8'h00), 16'h0040, "lw");
      step(0, 1, ins(4'd5, 8'h00), 16'h0080, "sw");

      step(0, 1, ins(4'd7, 8'hA5), 16'h0100, "sm_a5");
      drain("sm_a5");

      step(0, 1, ins(4'd6, 8'hFF), 16'hFFFC, "lm_ff");
      drain("lm_ff");
      step(0, 1, ins(4'd4, 8'h00), 16'h1234, "lw_after");

      step(0, 1, ins(4'd6, 8'h00), 16'h2000, "lm_00");
      step(0, 1, ins(4'd6, 8'h80), 16'h3000, "lm_80");
      step(0, 1, ins(4'd3, 8'h12), 16'h0000, "alu");

      step(0, 1, ins(4'd7, 8'hFF), 16'h4000, "sm_rst");
      junk("sm_rst");
      step(1, 1, 16'($urandom), 16'($urandom), "sm_rst_edge");
      step(0, 1, ins(4'd5, 8'h00), 16'h5000, "sw_post_rst");

      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 19));
         if (sel == 0)       step(1, 1'($urandom), 16'($urandom), 16'($urandom), "rnd_rst");
         else if (sel < 3)   step(0, 0, 16'($urandom), 16'($urandom), "rnd_bub");
         else begin
            opc = (sel < 8) ? 4'(4 + (sel % 4)) : 4'($urandom);
            step(0, 1, ins(opc, (sel == 9) ? 8'($urandom_range(0, 1)) : 8'($urandom)),
                 16'($urandom), "rnd");
         end
      end
      drain("rnd_tail");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
